// File: rtl/wb_ram_bytesel_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_ram_bytesel_pkg
// Description : Shared types and constants for the byte-select Wishbone RAM:
//               FSM state encoding, geometry helpers and the default fill word.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_ram_bytesel_pkg;

  // Controller states; 2-bit encoding is fixed so the state register is small
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  // RV32 "add x0,x0,x0": a harmless instruction if the RAM is fetched from
  localparam logic [31:0] DEFAULT_INIT_WORD = 32'h0000_0033;

  // Number of words for a capacity given in KB
  function automatic int mem_depth(input int mem_size_kb, input int data_width);
    return (mem_size_kb * 1024) / (data_width / 8);
  endfunction

  // Word-address width for a given depth (never below 1 bit)
  function automatic int mem_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ram_bytesel_if.sv
`default_nettype none
// ============================================================================
// Interface   : wb_ram_bytesel_if
// Description : Wishbone classic bus bundle between an initiator and the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_ram_bytesel_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic                    stb;
  logic                    cyc;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ack;

  modport master (
    output adr, wdata, sel, we, stb, cyc,
    input  rdata, ack
  );

  modport slave (
    input  adr, wdata, sel, we, stb, cyc,
    output rdata, ack
  );

endinterface
`default_nettype wire

// File: rtl/wb_ram_bytesel_sram.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_bytesel_sram
// Description : Single-port storage array with per-byte write enables and a
//               registered read port that returns zero when not reading.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_bytesel_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic [ADDR_WIDTH-1:0]   addr,
  input  wire logic                    we,
  input  wire logic [DATA_WIDTH/8-1:0] be,
  input  wire logic [DATA_WIDTH-1:0]   wdata,
  input  wire logic                    re,
  output logic      [DATA_WIDTH-1:0]   rdata
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write: only lanes with their enable set are modified
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < LANES; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Registered read; the output is held at zero except in the cycle after a read
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
    else         rdata <= '0;
  end

endmodule
`default_nettype wire

// File: rtl/wb_ram_bytesel.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_bytesel
// Description : Wishbone classic slave SRAM with byte-lane writes, a
//               programmable number of wait states and a hardware init sweep
//               that fills every word with INIT_WORD after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_bytesel
  import wb_ram_bytesel_pkg::*;
#(
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      MEM_SIZE    = 1,
  parameter int                      WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0]   INIT_WORD   = DATA_WIDTH'(DEFAULT_INIT_WORD)
) (
`ifdef USE_POWER_PINS
  inout  wire                        vccd1,
  inout  wire                        vssd1,
`endif
  input  wire logic                  clk,
  input  wire logic                  rst,
  wb_ram_bytesel_if.slave            bus,
  output logic                       init_done
);

  localparam int DEPTH      = mem_depth(MEM_SIZE, DATA_WIDTH);
  localparam int ADDR_WIDTH = mem_addr_width(DEPTH);
  localparam int LANES      = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_STATES);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [3:0]              wait_cnt;
  logic                    ack_reg;
  logic [ADDR_WIDTH-1:0]   req_adr;
  logic [DATA_WIDTH-1:0]   req_dat;
  logic [LANES-1:0]        req_sel;
  logic                    req_we;

  logic                    init_wr;
  logic                    access;
  logic                    mem_we;
  logic                    mem_re;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [LANES-1:0]        mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  // The edge that enters ACK is the one that performs the memory access;
  // reset suppresses any write that would otherwise land on that edge.
  assign init_wr = (state == ST_INIT) && !rst;
  assign access  = (state == ST_WAIT) && bus.cyc && (wait_cnt == 4'd0) && !rst;

  // The init sweep owns the memory port while it runs, with all lanes enabled
  assign mem_we    = init_wr || (access && req_we);
  assign mem_re    = access && !req_we;
  assign mem_addr  = (state == ST_INIT) ? init_cnt : req_adr;
  assign mem_be    = (state == ST_INIT) ? {LANES{1'b1}} : req_sel;
  assign mem_wdata = (state == ST_INIT) ? INIT_WORD : req_dat;

  assign bus.ack   = ack_reg;
  assign bus.rdata = ram_rdata;

  wb_ram_bytesel_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .addr  (mem_addr),
    .we    (mem_we),
    .be    (mem_be),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (ram_rdata)
  );

  // Controller: init sweep, request capture, wait countdown and one-cycle ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      wait_cnt  <= '0;
      ack_reg   <= 1'b0;
      init_done <= 1'b0;
      req_adr   <= '0;
      req_dat   <= '0;
      req_sel   <= '0;
      req_we    <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.cyc && bus.stb) begin
            req_adr  <= bus.adr;
            req_dat  <= bus.wdata;
            req_sel  <= bus.sel;
            req_we   <= bus.we;
            wait_cnt <= WAIT_LOAD;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A count of zero means the access happens on this edge
          if (!bus.cyc) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state   <= ST_ACK;
            ack_reg <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          // stb still belongs to the finished request, so it is not sampled here
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
